// File: rtl/store_merge_unit.sv
// Store path between the control FSM and the 64-bit data memory.
// Read-modify-write for sb/sh/sw, direct write for sd, rejects bad stores.
module store_merge_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] store_data,
    input  logic [63:0] mem_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_write,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [63:0] addr_q;
    logic [63:0] data_q;
    logic [63:0] buf_q;
    logic [2:0]  f3_q;

    logic        illegal;
    logic        misalign;
    logic        bad;
    logic        is_sd;

    logic [7:0]  size_en;
    logic [7:0]  byte_en;
    logic [63:0] byte_mask;
    logic [63:0] shifted;
    logic [63:0] merged;

    // Request checks run on the live inputs so the IDLE decision is one edge.
    always_comb begin
        illegal  = funct3[2];
        misalign = 1'b0;
        case (funct3[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = addr[0];
            2'b10:   misalign = |addr[1:0];
            default: misalign = |addr[2:0];
        endcase
        bad   = illegal | misalign;
        is_sd = (funct3[1:0] == 2'b11);
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (bad)
                        state_d = S_ERR;
                    else if (is_sd)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_WRITE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Little-endian byte lanes; sd enables all eight so buf_q is don't-care.
    always_comb begin
        size_en = 8'h00;
        if (!f3_q[2]) begin
            case (f3_q[1:0])
                2'b00:   size_en = 8'h01;
                2'b01:   size_en = 8'h03;
                2'b10:   size_en = 8'h0F;
                default: size_en = 8'hFF;
            endcase
        end
        byte_en = size_en << addr_q[2:0];
        for (int i = 0; i < 8; i++) begin
            byte_mask[8*i +: 8] = {8{byte_en[i]}};
        end
        shifted = data_q << {addr_q[2:0], 3'b000};
        merged  = (buf_q & ~byte_mask) | (shifted & byte_mask);
    end

    assign mem_wdata = (state == S_WRITE) ? merged : 64'd0;

    // Control outputs are registered from the next state, so none of them
    // has a combinational path from start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr_q    <= 64'd0;
            data_q    <= 64'd0;
            buf_q     <= 64'd0;
            f3_q      <= 3'd0;
            mem_addr  <= 64'd0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            busy      <= (state_d != S_IDLE);
            mem_write <= (state_d == S_WRITE);
            done      <= (state_d == S_DONE);
            err       <= (state_d == S_ERR);

            if (state == S_IDLE && start) begin
                addr_q <= addr;
                f3_q   <= funct3;
                data_q <= store_data;
            end

            if (state == S_WAIT)
                buf_q <= mem_rdata;

            if (state_d == S_IDLE)
                mem_addr <= 64'd0;
            else if (state == S_IDLE)
                mem_addr <= {addr[63:3], 3'b000};
            else
                mem_addr <= {addr_q[63:3], 3'b000};
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: memory model plus a byte-level
// reference memory driven by directed and random stores.
module tb_store_merge_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] store_data;
    logic [63:0] mem_rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_write;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [63:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [63:0] pl_val;
    logic [7:0]  ref_b [0:511];

    always #5 clk = ~clk;

    store_merge_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (mem_write)
            mem[mem_addr[8:3]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[8:3]];
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_dw(input int idx);
        logic [63:0] r;
        for (int b = 0; b < 8; b++)
            r[8*b +: 8] = ref_b[idx*8 + b];
        return r;
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic preload(input int idx, input logic [63:0] v);
        pl_en  = 1'b1;
        pl_idx = idx[5:0];
        pl_val = v;
        for (int b = 0; b < 8; b++)
            ref_b[idx*8 + b] = v[8*b +: 8];
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of
    // the first idle cycle so a following call issues back-to-back.
    task automatic store(input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, input bit junk);
        int          size;
        int          ai;
        bit          bad;
        int          eb, ewc, edc, eec;
        int          blen;
        int          wc, dc, ec;
        int          wcyc, dcyc, ecyc;
        logic [63:0] wd, wa, ra, exp_wd, idle_addr;

        size = 1 << f3[1:0];
        ai   = int'(a[8:0]);
        bad  = f3[2] || ((int'(a[2:0]) % size) != 0);
        exp_wd = 64'd0;
        if (!bad) begin
            for (int i = 0; i < size; i++)
                ref_b[ai + i] = d[8*i +: 8];
            exp_wd = ref_dw(ai >> 3);
        end
        if (bad) begin
            eb = 1; ewc = 0; edc = 0; eec = 1;
        end else if (f3[1:0] == 2'b11) begin
            eb = 2; ewc = 1; edc = 2; eec = 0;
        end else begin
            eb = 4; ewc = 3; edc = 4; eec = 0;
        end

        blen = -1; wc = 0; dc = 0; ec = 0;
        wcyc = 0; dcyc = 0; ecyc = 0;
        wd = 64'd0; wa = 64'd0; ra = 64'd0; idle_addr = 64'hX;

        funct3     = f3;
        addr       = a;
        store_data = d;
        start      = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) ra = mem_addr;
            if (mem_write) begin
                wc++; wcyc = k; wd = mem_wdata; wa = mem_addr;
            end
            if (done) begin dc++; dcyc = k; end
            if (err)  begin ec++; ecyc = k; end
            if (!busy) begin
                blen = k - 1;
                idle_addr = mem_addr;
                break;
            end
            if (junk) begin
                start      = 1'($urandom_range(0, 1));
                funct3     = 3'($urandom_range(0, 7));
                addr       = {$urandom, $urandom};
                store_data = {$urandom, $urandom};
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;

        check("busy_len",  64'(blen), 64'(eb));
        check("write_cnt", 64'(wc),   64'(ewc != 0));
        check("done_cnt",  64'(dc),   64'(edc != 0));
        check("err_cnt",   64'(ec),   64'(eec != 0));
        check("write_cyc", 64'(wcyc), 64'(ewc));
        check("done_cyc",  64'(dcyc), 64'(edc));
        check("err_cyc",   64'(ecyc), 64'(eec));
        check("rd_addr",   ra, {a[63:3], 3'b000});
        check("idle_addr", idle_addr, 64'd0);
        if (!bad) begin
            check("wr_addr", wa, {a[63:3], 3'b000});
            check("wr_data", wd, exp_wd);
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [63:0] a;
        int          sz;
        bit          sb_wr;

        reset = 1'b1; start = 1'b0; funct3 = 3'd0;
        addr = 64'd0; store_data = 64'd0;
        pl_en = 1'b0; pl_idx = 6'd0; pl_val = 64'd0;

        @(negedge clk);
        for (int i = 0; i < 64; i++)
            preload(i, {$urandom, $urandom});
        @(posedge clk);
        #1;
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_done",  64'(done),      64'd0);
        check("rst_err",   64'(err),       64'd0);
        check("rst_write", 64'(mem_write), 64'd0);
        check("rst_addr",  mem_addr,       64'd0);
        check("rst_wdata", mem_wdata,      64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        store(3'b011, 64'h40, 64'h1122334455667788, 1'b0);
        check("sd_mem", mem[8], 64'h1122334455667788);

        preload(8, 64'hFFFFFFFFFFFFFFFF);
        store(3'b000, 64'h45, 64'hAB, 1'b0);
        @(negedge clk);
        check("sb_mem", mem[8], 64'hFFFFABFFFFFFFFFF);

        preload(2, 64'd0);
        store(3'b001, 64'h16, 64'hBEEF, 1'b0);
        check("sh_mem", mem[2], 64'hBEEF000000000000);
        store(3'b010, 64'h14, 64'hCAFEF00D, 1'b0);
        @(negedge clk);
        check("sw_mem", mem[2], 64'hCAFEF00D00000000);

        store(3'b010, 64'h22, 64'h12345678, 1'b0);
        store(3'b100, 64'h40, 64'h12345678, 1'b0);
        @(negedge clk);

        store(3'b000, 64'h1A3, 64'h5A, 1'b1);
        @(negedge clk);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) == 0)
                f3 = 3'($urandom_range(4, 7));
            else
                f3 = 3'($urandom_range(0, 3));
            a  = 64'($urandom_range(0, 511));
            sz = 1 << f3[1:0];
            if ($urandom_range(0, 2) != 0)
                a = a & ~64'(sz - 1);
            store(f3, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1)
                @(negedge clk);
        end

        // Reset during WAIT of an sb: no write, back to idle.
        @(negedge clk);
        funct3 = 3'b000; addr = 64'h45; store_data = 64'h77;
        start = 1'b1;
        @(posedge clk);
        sb_wr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        sb_wr = sb_wr | mem_write;
        @(negedge clk);
        sb_wr = sb_wr | mem_write;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mr_busy",  64'(busy),      64'd0);
        check("mr_write", 64'(mem_write), 64'd0);
        check("mr_done",  64'(done),      64'd0);
        check("mr_err",   64'(err),       64'd0);
        check("mr_addr",  mem_addr,       64'd0);
        check("mr_wdata", mem_wdata,      64'd0);
        @(negedge clk);
        reset = 1'b0;
        sb_wr = sb_wr | mem_write;
        check("mr_nowr", 64'(sb_wr), 64'd0);
        @(negedge clk);
        check("mr_mem", mem[8], ref_dw(8));

        store(3'b011, 64'h48, 64'h0F1E2D3C4B5A6978, 1'b0);
        @(negedge clk);
        check("mr_sd", mem[9], 64'h0F1E2D3C4B5A6978);

        for (int i = 0; i < 64; i++)
            check("mem_final", mem[i], ref_dw(i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
